// File: rtl/imm_pkg.sv
// Shared opcodes, immediate format codes and skid-buffer state encoding
// for the registered immediate-decode stage.
package imm_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] TYPE_NONE = 3'b000;
  localparam logic [2:0] TYPE_U    = 3'b001;
  localparam logic [2:0] TYPE_S    = 3'b010;
  localparam logic [2:0] TYPE_B    = 3'b011;
  localparam logic [2:0] TYPE_I    = 3'b100;
  localparam logic [2:0] TYPE_J    = 3'b101;
  localparam logic [2:0] TYPE_JALR = 3'b110;
  localparam logic [2:0] TYPE_L    = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RV32I/RV64I immediate extraction, format classification
// and unknown-opcode detection.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit RV64_EN = 1'b0
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Sign extension is done by filling with inst[31] and then overwriting
  // the low bits, which works for both XLEN values without zero replications.
  always_comb begin
    imm     = '0;
    fmt     = TYPE_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        fmt        = TYPE_U;
        imm        = {XLEN{inst[31]}};
        imm[31:0]  = {inst[31:12], 12'b0};
      end
      OP_STORE: begin
        fmt        = TYPE_S;
        imm        = {XLEN{inst[31]}};
        imm[11:0]  = {inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        fmt        = TYPE_B;
        imm        = {XLEN{inst[31]}};
        imm[12:0]  = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_IMM, OP_IMM32: begin
        if (opcode == OP_IMM32 && !RV64_EN) begin
          illegal = 1'b1;
        end else begin
          fmt = TYPE_I;
          if (is_shift) begin
            if (RV64_EN && opcode == OP_IMM) imm[5:0] = inst[25:20];
            else                             imm[4:0] = inst[24:20];
          end else begin
            imm       = {XLEN{inst[31]}};
            imm[11:0] = inst[31:20];
          end
        end
      end
      OP_JAL: begin
        fmt        = TYPE_J;
        imm        = {XLEN{inst[31]}};
        imm[20:0]  = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_JALR: begin
        fmt        = TYPE_JALR;
        imm        = {XLEN{inst[31]}};
        imm[11:0]  = inst[31:20];
      end
      OP_LOAD: begin
        fmt        = TYPE_L;
        imm        = {XLEN{inst[31]}};
        imm[11:0]  = inst[31:20];
      end
      OP_REG, OP_FENCE: begin
        fmt = TYPE_NONE;
      end
      OP_REG32: begin
        illegal = !RV64_EN;
      end
      OP_SYSTEM: begin
        imm[4:0] = inst[19:15];
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with valid/ready on both sides and a
// 2-entry skid buffer so in_ready is registered and independent of out_ready.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit RV64_EN = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal
);

  state_t          state_q, state_d;
  logic            in_ready_q;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_illegal;

  logic [31:0]     main_inst, skid_inst;
  logic [XLEN-1:0] main_pc, skid_pc;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic [2:0]      main_type, skid_type;
  logic            main_illegal, skid_illegal;

  logic            in_fire, out_fire;
  logic            load_main, load_skid, main_from_skid;

  imm_decode_comb #(
    .XLEN    (XLEN),
    .RV64_EN (RV64_EN)
  ) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_type),
    .illegal (dec_illegal)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  // Flush overrides any same-cycle transfer, so no load strobes fire under it.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_inst    <= '0;
      main_pc      <= '0;
      main_imm     <= '0;
      main_type    <= TYPE_NONE;
      main_illegal <= 1'b0;
      skid_inst    <= '0;
      skid_pc      <= '0;
      skid_imm     <= '0;
      skid_type    <= TYPE_NONE;
      skid_illegal <= 1'b0;
    end else begin
      if (load_main) begin
        main_inst    <= in_inst;
        main_pc      <= in_pc;
        main_imm     <= dec_imm;
        main_type    <= dec_type;
        main_illegal <= dec_illegal;
      end else if (main_from_skid) begin
        main_inst    <= skid_inst;
        main_pc      <= skid_pc;
        main_imm     <= skid_imm;
        main_type    <= skid_type;
        main_illegal <= skid_illegal;
      end
      if (load_skid) begin
        skid_inst    <= in_inst;
        skid_pc      <= in_pc;
        skid_imm     <= dec_imm;
        skid_type    <= dec_type;
        skid_illegal <= dec_illegal;
      end
    end
  end

  assign out_inst    = main_inst;
  assign out_pc      = main_pc;
  assign out_imm     = main_imm;
  assign out_type    = main_type;
  assign out_illegal = main_illegal;

endmodule
